// File: rtl/common_types_pkg.sv
// Shared types and constants for the AHB timer slice.
// - word_t / htrans_t : AHB-Lite data word and transfer-type encodings
// - REG_*             : register byte offsets within the timer window
// - IDX_*             : the same offsets as word indices (haddr[4:2])
// - CTRL_*            : bit positions inside CTRL
// - tmr_state_t       : bus response FSM states
package common_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [4:0] REG_CTRL     = 5'h00;
  localparam logic [4:0] REG_COUNT    = 5'h04;
  localparam logic [4:0] REG_COMPARE  = 5'h08;
  localparam logic [4:0] REG_STATUS   = 5'h0C;
  localparam logic [4:0] REG_PRESCALE = 5'h10;

  localparam logic [2:0] IDX_CTRL     = REG_CTRL[4:2];
  localparam logic [2:0] IDX_COUNT    = REG_COUNT[4:2];
  localparam logic [2:0] IDX_COMPARE  = REG_COMPARE[4:2];
  localparam logic [2:0] IDX_STATUS   = REG_STATUS[4:2];
  localparam logic [2:0] IDX_PRESCALE = REG_PRESCALE[4:2];

  localparam int CTRL_EN          = 0;
  localparam int CTRL_IRQ_EN      = 1;
  localparam int CTRL_AUTO_RELOAD = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } tmr_state_t;

endpackage

// File: rtl/ahb_bus_if.sv
// AHB-Lite slave-side bundle as presented by the bus multiplexor.
// slave modport: hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready in;
//                hrdata, hreadyout, hresp out.
interface ahb_bus_if;
  import common_types_pkg::*;

  logic       hsel;
  word_t      haddr;
  htrans_t    htrans;
  logic       hwrite;
  logic [2:0] hsize;
  logic [2:0] hburst;
  word_t      hwdata;
  logic       hready;
  word_t      hrdata;
  logic       hreadyout;
  logic       hresp;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    output hrdata, hreadyout, hresp
  );

endinterface

// File: rtl/ahb_timer.sv
// AHB-Lite memory-mapped 32-bit timer with compare match and level interrupt.
// Ports:
//   clk  - system clock, rising edge
//   nrst - asynchronous active-low reset
//   bus  - ahb_bus_if.slave (address decode to this block is done in the mux)
//   irq  - STATUS.MATCH & CTRL.IRQ_EN
// Optional build macro AHB_TIMER_PRESCALE_EN adds the 16-bit PRESCALE register
// at offset 0x10; without it that offset answers with an ERROR response.
//
// Response FSM:
//   state   | meaning
//   ST_IDLE | no data phase in progress
//   ST_DATA | zero-wait OKAY data phase of an accepted transfer
//   ST_ERR1 | first ERROR cycle (hreadyout low)
//   ST_ERR2 | second ERROR cycle (hreadyout high), may accept next transfer
module ahb_timer
  import common_types_pkg::*;
#(
  parameter word_t COMPARE_RST = 32'hFFFF_FFFF
) (
  input  logic      clk,
  input  logic      nrst,
  ahb_bus_if.slave  bus,
  output logic      irq
);

  tmr_state_t r_state, w_state_nxt;
  logic [2:0] r_idx;
  logic       r_write;

  logic [2:0] r_ctrl;
  word_t      r_count;
  word_t      r_compare;
  logic       r_match;

  logic [2:0] w_idx;
  logic       w_mapped, w_accept, w_err;
  logic       w_wr, w_wr_ctrl, w_wr_count, w_wr_compare, w_wr_status;
  logic       w_tick, w_set_match;
  logic       w_hreadyout, w_hresp;
  word_t      w_rdata;
  logic       w_unused;

  assign w_unused = ^{bus.hburst, bus.haddr[31:5]};
  assign w_idx    = bus.haddr[4:2];

`ifdef AHB_TIMER_PRESCALE_EN
  assign w_mapped = (w_idx <= IDX_PRESCALE);
`else
  assign w_mapped = (w_idx <= IDX_STATUS);
`endif

  assign w_accept = bus.hsel & bus.hready &
                    ((bus.htrans == HTRANS_NONSEQ) | (bus.htrans == HTRANS_SEQ));
  assign w_err    = (bus.hsize != HSIZE_WORD) | (bus.haddr[1:0] != 2'b00) | ~w_mapped;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_idx   <= w_idx;
        r_write <= bus.hwrite;
      end
    end
  end

  // hready is low only during ERR1, so no new address phase can be accepted there.
  always_comb begin
    w_state_nxt = ST_IDLE;
    w_hreadyout = 1'b1;
    w_hresp     = 1'b0;
    case (r_state)
      ST_ERR1: begin
        w_state_nxt = ST_ERR2;
        w_hreadyout = 1'b0;
        w_hresp     = 1'b1;
      end
      ST_ERR2: begin
        w_hresp = 1'b1;
        if (w_accept) w_state_nxt = w_err ? ST_ERR1 : ST_DATA;
      end
      default: begin
        if (w_accept) w_state_nxt = w_err ? ST_ERR1 : ST_DATA;
      end
    endcase
  end

  assign bus.hreadyout = w_hreadyout;
  assign bus.hresp     = w_hresp;

  assign w_wr         = (r_state == ST_DATA) & r_write;
  assign w_wr_ctrl    = w_wr & (r_idx == IDX_CTRL);
  assign w_wr_count   = w_wr & (r_idx == IDX_COUNT);
  assign w_wr_compare = w_wr & (r_idx == IDX_COMPARE);
  assign w_wr_status  = w_wr & (r_idx == IDX_STATUS);

`ifdef AHB_TIMER_PRESCALE_EN
  logic [15:0] r_prescale, r_pre_cnt;
  logic        w_wr_prescale;

  assign w_wr_prescale = w_wr & (r_idx == IDX_PRESCALE);
  assign w_tick        = r_ctrl[CTRL_EN] & (r_pre_cnt == r_prescale);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_prescale <= '0;
      r_pre_cnt  <= '0;
    end else begin
      if (w_wr_prescale) r_prescale <= bus.hwdata[15:0];
      if (!r_ctrl[CTRL_EN] || w_wr_prescale || w_tick) r_pre_cnt <= '0;
      else                                            r_pre_cnt <= r_pre_cnt + 16'd1;
    end
  end
`else
  assign w_tick = r_ctrl[CTRL_EN];
`endif

  // A COUNT write suppresses both the increment and the compare for that cycle.
  assign w_set_match = w_tick & ~w_wr_count & (r_count == r_compare);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_ctrl    <= '0;
      r_count   <= '0;
      r_compare <= COMPARE_RST;
      r_match   <= 1'b0;
    end else begin
      if (w_wr_ctrl)    r_ctrl    <= bus.hwdata[2:0];
      if (w_wr_compare) r_compare <= bus.hwdata;
      if (w_wr_count)
        r_count <= bus.hwdata;
      else if (w_tick)
        r_count <= (w_set_match & r_ctrl[CTRL_AUTO_RELOAD]) ? '0 : r_count + 32'd1;
      // A match set by the tick wins over a simultaneous write-1-to-clear.
      if (w_set_match)                         r_match <= 1'b1;
      else if (w_wr_status && bus.hwdata[0])   r_match <= 1'b0;
    end
  end

  // Read data reflects register contents at the start of the data phase.
  always_comb begin
    w_rdata = '0;
    if (r_state == ST_DATA && !r_write) begin
      case (r_idx)
        IDX_CTRL:     w_rdata = {29'b0, r_ctrl};
        IDX_COUNT:    w_rdata = r_count;
        IDX_COMPARE:  w_rdata = r_compare;
        IDX_STATUS:   w_rdata = {31'b0, r_match};
`ifdef AHB_TIMER_PRESCALE_EN
        IDX_PRESCALE: w_rdata = {16'b0, r_prescale};
`endif
        default:      w_rdata = '0;
      endcase
    end
  end

  assign bus.hrdata = w_rdata;
  assign irq        = r_match & r_ctrl[CTRL_IRQ_EN];

endmodule

// File: tb/tb_ahb_timer.sv
module tb_ahb_timer;
  import common_types_pkg::*;

  localparam word_t BASE = 32'h0003_0000;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic irq;

  ahb_bus_if bus();
  assign bus.hready = bus.hreadyout;

  ahb_timer #(.COMPARE_RST(32'hFFFF_FFFF)) dut (
    .clk(clk), .nrst(nrst), .bus(bus), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural register model
  logic [2:0]  m_ctrl;
  word_t       m_count, m_compare;
  logic        m_match;
  logic [15:0] m_prescale;
`ifdef AHB_TIMER_PRESCALE_EN
  int unsigned m_phase;
`endif
  bit          pend_wr;
  logic [2:0]  pend_idx;
  bit          irq_chk_on = 0;
  word_t       seq [16];

  typedef struct {
    bit         wr;
    word_t      addr;
    logic [2:0] size;
    word_t      wdata;
    bit         exp_err;
    word_t      exp_rdata;
  } vec_t;
  vec_t tbl [16];

  function automatic void check(input string name, input word_t act, input word_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_ctrl = '0; m_count = '0; m_compare = 32'hFFFF_FFFF; m_match = 1'b0; m_prescale = '0;
`ifdef AHB_TIMER_PRESCALE_EN
    m_phase = 0;
`endif
    pend_wr = 0; pend_idx = '0;
  endfunction

  function automatic bit mapped(input logic [2:0] idx);
`ifdef AHB_TIMER_PRESCALE_EN
    return idx <= 3'd4;
`else
    return idx <= 3'd3;
`endif
  endfunction

  function automatic word_t model_read(input logic [2:0] idx);
    case (idx)
      3'd0: return {29'b0, m_ctrl};
      3'd1: return m_count;
      3'd2: return m_compare;
      3'd3: return {31'b0, m_match};
      3'd4: return {16'b0, m_prescale};
      default: return '0;
    endcase
  endfunction

  // One clock edge of the timer as described by its rules: tick decision from
  // the state before the edge, then writes, COUNT write overriding the tick.
  function automatic void model_edge(input bit wr, input logic [2:0] idx, input word_t wd);
    bit tick, set_m;
    word_t nxt;
`ifdef AHB_TIMER_PRESCALE_EN
    tick = m_ctrl[0] && ((m_phase % (32'(m_prescale) + 1)) == 32'(m_prescale));
    if (!m_ctrl[0] || (wr && idx == 3'd4)) m_phase = 0;
    else                                   m_phase = m_phase + 1;
`else
    tick = m_ctrl[0];
`endif
    set_m = tick && !(wr && idx == 3'd1) && (m_count == m_compare);
    if (wr && idx == 3'd1) nxt = wd;
    else if (tick)         nxt = (set_m && m_ctrl[2]) ? 32'd0 : m_count + 32'd1;
    else                   nxt = m_count;
    if (wr && idx == 3'd3 && wd[0]) m_match = 1'b0;
    if (set_m)                      m_match = 1'b1;
    m_count = nxt;
    if (wr && idx == 3'd0) m_ctrl     = wd[2:0];
    if (wr && idx == 3'd2) m_compare  = wd;
    if (wr && idx == 3'd4) m_prescale = wd[15:0];
  endfunction

  always @(negedge clk)
    if (irq_chk_on) check("irq", {31'b0, irq}, {31'b0, m_match & m_ctrl[1]});

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clk_edge(input bit acc, input bit wr, input logic [2:0] idx);
    @(posedge clk);
    model_edge(pend_wr, pend_idx, bus.hwdata);
    pend_wr  = acc & wr;
    pend_idx = idx;
    #1;
  endtask

  task automatic drive_idle();
    bus.hsel = 1'b0; bus.haddr = '0; bus.htrans = HTRANS_IDLE;
    bus.hwrite = 1'b0; bus.hsize = 3'd2; bus.hburst = 3'd0;
  endtask

  task automatic xfer(input bit wr, input word_t addr, input logic [2:0] size,
                      input word_t wd, output word_t rdata, output logic resp1);
    bit err;
    logic [2:0] idx;
    idx = addr[4:2];
    err = (size != 3'd2) || (addr[1:0] != 2'b00) || !mapped(idx);
    bus.hsel = 1'b1; bus.haddr = addr; bus.hwrite = wr; bus.hsize = size;
    bus.htrans = ($urandom_range(0, 1) == 1) ? HTRANS_SEQ : HTRANS_NONSEQ;
    bus.hburst = 3'($urandom_range(0, 7));
    clk_edge(!err, wr, idx);
    drive_idle();
    bus.hwdata = wr ? wd : $urandom;
    @(negedge clk);
    rdata = bus.hrdata;
    resp1 = bus.hresp;
    if (!err) begin
      check("ok_hreadyout", {31'b0, bus.hreadyout}, 1);
      check("ok_hresp", {31'b0, bus.hresp}, 0);
      if (!wr) check("ok_hrdata", bus.hrdata, model_read(idx));
      clk_edge(0, 0, 0);
    end else begin
      check("err1_hreadyout", {31'b0, bus.hreadyout}, 0);
      check("err1_hresp", {31'b0, bus.hresp}, 1);
      check("err1_hrdata", bus.hrdata, 0);
      clk_edge(0, 0, 0);
      @(negedge clk);
      check("err2_hreadyout", {31'b0, bus.hreadyout}, 1);
      check("err2_hresp", {31'b0, bus.hresp}, 1);
      clk_edge(0, 0, 0);
    end
  endtask

  task automatic wr_reg(input logic [4:0] ofs, input word_t wd);
    word_t rd; logic r1;
    xfer(1, BASE | {27'b0, ofs}, 3'd2, wd, rd, r1);
  endtask

  task automatic burst_read(input logic [2:0] idx, input int n);
    bus.hsel = 1'b1; bus.haddr = BASE | {27'b0, idx, 2'b00};
    bus.htrans = HTRANS_NONSEQ; bus.hwrite = 1'b0; bus.hsize = 3'd2;
    clk_edge(1, 0, idx);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) drive_idle();
      else            bus.htrans = HTRANS_SEQ;
      @(negedge clk);
      check("burst_hreadyout", {31'b0, bus.hreadyout}, 1);
      check("burst_hrdata", bus.hrdata, model_read(idx));
      seq[i] = bus.hrdata;
      clk_edge(i < n - 1, 0, idx);
    end
  endtask

  initial begin
    word_t rd, wd, addr;
    logic  r1;
    int    pos;
    bit    found;

    drive_idle();
    bus.hwdata = '0;
    model_reset();

    tbl[0]  = '{0, BASE | 32'h00, 3'd2, 32'h0,         0, 32'h0};
    tbl[1]  = '{0, BASE | 32'h04, 3'd2, 32'h0,         0, 32'h0};
    tbl[2]  = '{0, BASE | 32'h08, 3'd2, 32'h0,         0, 32'hFFFF_FFFF};
    tbl[3]  = '{0, BASE | 32'h0C, 3'd2, 32'h0,         0, 32'h0};
    tbl[4]  = '{1, BASE | 32'h04, 3'd0, 32'h55,        1, 32'h0};
    tbl[5]  = '{0, BASE | 32'h04, 3'd2, 32'h0,         0, 32'h0};
    tbl[6]  = '{0, BASE | 32'h06, 3'd2, 32'h0,         1, 32'h0};
    tbl[7]  = '{0, BASE | 32'h14, 3'd2, 32'h0,         1, 32'h0};
    tbl[8]  = '{0, BASE | 32'h1C, 3'd2, 32'h0,         1, 32'h0};
`ifdef AHB_TIMER_PRESCALE_EN
    tbl[9]  = '{0, BASE | 32'h10, 3'd2, 32'h0,         0, 32'h0};
`else
    tbl[9]  = '{0, BASE | 32'h10, 3'd2, 32'h0,         1, 32'h0};
`endif
    tbl[10] = '{1, BASE | 32'h08, 3'd2, 32'h1234,      0, 32'h0};
    tbl[11] = '{0, BASE | 32'h08, 3'd2, 32'h0,         0, 32'h1234};
    tbl[12] = '{1, BASE | 32'h00, 3'd2, 32'hFFFF_FFF8, 0, 32'h0};
    tbl[13] = '{0, BASE | 32'h00, 3'd2, 32'h0,         0, 32'h0};
    tbl[14] = '{1, BASE | 32'h08, 3'd1, 32'h0,         1, 32'h0};
    tbl[15] = '{0, BASE | 32'h08, 3'd2, 32'h0,         0, 32'h1234};

    // reset state
    #12;
    check("rst_hreadyout", {31'b0, bus.hreadyout}, 1);
    check("rst_hresp", {31'b0, bus.hresp}, 0);
    check("rst_hrdata", bus.hrdata, 0);
    check("rst_irq", {31'b0, irq}, 0);
    @(negedge clk);
    nrst = 1'b1;
    clk_edge(0, 0, 0);
    irq_chk_on = 1;

    // table of single transfers
    for (int i = 0; i < 16; i++) begin
      xfer(tbl[i].wr, tbl[i].addr, tbl[i].size, tbl[i].wdata, rd, r1);
      check($sformatf("tbl%0d_resp", i), {31'b0, r1}, {31'b0, tbl[i].exp_err});
      if (!tbl[i].wr) check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
    end

    // match without auto-reload, irq disabled
    wr_reg(REG_COMPARE, 32'd5);
    wr_reg(REG_CTRL, 32'h1);
    burst_read(IDX_COUNT, 10);
    found = 0; pos = 0;
    for (int i = 0; i < 9; i++) if (!found && seq[i] == 32'd5) begin found = 1; pos = i; end
    check("s1_saw5", {31'b0, found}, 1);
    if (found) check("s1_after5", seq[pos+1], 32'd6);
    xfer(0, BASE | 32'h0C, 3'd2, 0, rd, r1);
    check("s1_match", rd, 1);
    check("s1_irq", {31'b0, irq}, 0);

    // auto-reload with irq, then W1C
    wr_reg(REG_CTRL, 32'h0);
    wr_reg(REG_COUNT, 32'h0);
    wr_reg(REG_STATUS, 32'h1);
    wr_reg(REG_COMPARE, 32'd3);
    wr_reg(REG_CTRL, 32'h7);
    burst_read(IDX_COUNT, 10);
    for (int i = 0; i < 9; i++)
      check("s2_seq", seq[i+1], (seq[i] == 32'd3) ? 32'd0 : seq[i] + 32'd1);
    check("s2_irq_set", {31'b0, irq}, 1);
    wr_reg(REG_CTRL, 32'h6);
    check("s2_irq_hold", {31'b0, irq}, 1);
    wr_reg(REG_STATUS, 32'h1);
    check("s2_irq_clr", {31'b0, irq}, 0);

    // wrap through 0xFFFF_FFFF, then match at 0
    wr_reg(REG_CTRL, 32'h0);
    wr_reg(REG_COMPARE, 32'h0);
    wr_reg(REG_STATUS, 32'h1);
    wr_reg(REG_COUNT, 32'hFFFF_FFFE);
    wr_reg(REG_CTRL, 32'h1);
    burst_read(IDX_COUNT, 4);
    check("s3_ffff", seq[0], 32'hFFFF_FFFF);
    check("s3_zero", seq[1], 32'h0);
    check("s3_one", seq[2], 32'h1);
    xfer(0, BASE | 32'h0C, 3'd2, 0, rd, r1);
    check("s3_match", rd, 1);

    // back-to-back write then read of COMPARE
    bus.hsel = 1'b1; bus.haddr = BASE | 32'h08; bus.htrans = HTRANS_NONSEQ;
    bus.hwrite = 1'b1; bus.hsize = 3'd2;
    clk_edge(1, 1, IDX_COMPARE);
    bus.hwrite = 1'b0; bus.hwdata = 32'hCAFE_0042;
    @(negedge clk);
    check("b2b_wr_hreadyout", {31'b0, bus.hreadyout}, 1);
    check("b2b_wr_hresp", {31'b0, bus.hresp}, 0);
    clk_edge(1, 0, IDX_COMPARE);
    drive_idle();
    @(negedge clk);
    check("b2b_rd_hreadyout", {31'b0, bus.hreadyout}, 1);
    check("b2b_rdata", bus.hrdata, 32'hCAFE_0042);
    clk_edge(0, 0, 0);

    // prescale
`ifdef AHB_TIMER_PRESCALE_EN
    wr_reg(REG_CTRL, 32'h0);
    wr_reg(REG_COMPARE, 32'hFFFF_0000);
    wr_reg(REG_COUNT, 32'h0);
    wr_reg(REG_PRESCALE, 32'd2);
    wr_reg(REG_CTRL, 32'h1);
    burst_read(IDX_COUNT, 12);
    check("s6_span_ok", {31'b0, ((seq[11] - seq[0]) == 32'd3) || ((seq[11] - seq[0]) == 32'd4)}, 1);
`else
    xfer(1, BASE | 32'h10, 3'd2, 32'd2, rd, r1);
    check("s6_prescale_err", {31'b0, r1}, 1);
`endif

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        bus.hsel   = 1'($urandom_range(0, 1));
        bus.haddr  = BASE | {27'b0, 3'($urandom_range(0, 4)), 2'b00};
        bus.hwrite = 1'b1; bus.hsize = 3'd2;
        bus.htrans = bus.hsel ? (($urandom_range(0, 1) == 1) ? HTRANS_BUSY : HTRANS_IDLE) : HTRANS_NONSEQ;
        bus.hwdata = $urandom;
        clk_edge(0, 0, 0);
        drive_idle();
        @(negedge clk);
        check("noop_hreadyout", {31'b0, bus.hreadyout}, 1);
        check("noop_hresp", {31'b0, bus.hresp}, 0);
        clk_edge(0, 0, 0);
      end else begin
        logic [2:0] idx;
        logic [2:0] size;
        bit wr;
        idx  = (k % 2 == 1) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 7));
        addr = BASE | {27'b0, idx, 2'b00};
        if ($urandom_range(0, 15) == 0) addr[1:0] = 2'($urandom_range(1, 3));
        size = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 1)) : 3'd2;
        wr   = 1'($urandom_range(0, 1));
        case (idx)
          3'd1, 3'd2: wd = 32'($urandom_range(0, 48));
          3'd4:       wd = 32'($urandom_range(0, 5));
          default:    wd = $urandom;
        endcase
        xfer(wr, addr, size, wd, rd, r1);
        repeat ($urandom_range(0, 2)) clk_edge(0, 0, 0);
      end
    end

    // reset in the middle of a write data phase
    wr_reg(REG_CTRL, 32'h7);
    bus.hsel = 1'b1; bus.haddr = BASE | 32'h08; bus.htrans = HTRANS_NONSEQ;
    bus.hwrite = 1'b1; bus.hsize = 3'd2;
    clk_edge(1, 1, IDX_COMPARE);
    drive_idle();
    bus.hwdata = 32'h0000_00AA;
    @(negedge clk);
    irq_chk_on = 0;
    #2 nrst = 1'b0;
    model_reset();
    #1;
    check("mid_rst_hreadyout", {31'b0, bus.hreadyout}, 1);
    check("mid_rst_hresp", {31'b0, bus.hresp}, 0);
    check("mid_rst_hrdata", bus.hrdata, 0);
    check("mid_rst_irq", {31'b0, irq}, 0);
    @(negedge clk);
    nrst = 1'b1;
    irq_chk_on = 1;
    clk_edge(0, 0, 0);
    xfer(0, BASE | 32'h08, 3'd2, 0, rd, r1);
    check("mid_rst_compare", rd, 32'hFFFF_FFFF);
    xfer(0, BASE | 32'h00, 3'd2, 0, rd, r1);
    check("mid_rst_ctrl", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_timer.md
AHB_TIMER -- requirements
Module: ahb_timer

Interface
REQ-001 SHALL have parameter COMPARE_RST, default 32'hFFFF_FFFF, meaning the reset value of the COMPARE register.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port nrst  input  1  reset; asynchronous assert, active-low.
REQ-004 SHALL carry the following AHB-Lite slave signals on the ahb_bus_if slave-side modport, as driven by the bus multiplexor:
- hsel  input  1
- haddr  input  32
- htrans  input  2
- hwrite  input  1
- hsize  input  3
- hburst  input  3 (ignored)
- hwdata  input  32
- hready  input  1
- hrdata  output  32
- hreadyout  output  1
- hresp  output  1
REQ-005 SHALL have port irq  output  1  level interrupt to core = STATUS.MATCH & CTRL.IRQ_EN, driven from registers only.

Function
REQ-006 SHALL decode haddr[4:2] only; register map:
- 0x0 CTRL: b0 EN, b1 IRQ_EN, b2 AUTO_RELOAD; other bits read 0.
- 0x4 COUNT: RW, 32 bits.
- 0x8 COMPARE: RW, 32 bits.
- 0xC STATUS: b0 MATCH, write-1-to-clear.
- 0x10 PRESCALE: present only under the macro in REQ-020.
REQ-007 SHALL accept a transfer when hsel & hready & htrans in {NONSEQ, SEQ} at a rising edge, latching haddr, hwrite and hsize for the data phase.
REQ-008 SHALL treat IDLE and BUSY transfers, and cycles with hsel=0, as no-ops with an OKAY response.
REQ-009 SHALL complete valid transfers with zero wait states: hreadyout=1 and hresp=OKAY in the data phase.
REQ-010 SHALL apply write data from hwdata at the end of the data phase.
REQ-011 SHALL drive hrdata in the data phase from the register value at the start of that phase.
REQ-012 SHALL treat any of the following as an error transfer: hsize != word, haddr[1:0] != 0, or an unmapped offset.
REQ-013 SHALL answer an error transfer with the two-cycle AHB ERROR response:
- cycle 1: hreadyout=0, hresp=1;
- cycle 2: hreadyout=1, hresp=1;
- no register is modified;
- hrdata=0.
REQ-014 SHALL implement the response logic as an FSM with states IDLE, DATA, ERR1 and ERR2:
- IDLE->DATA on a valid accept;
- IDLE->ERR1 on an error accept;
- DATA->DATA, DATA->ERR1 or DATA->IDLE according to the next address phase;
- ERR1->ERR2 unconditionally;
- ERR2->IDLE, ERR2->DATA or ERR2->ERR1 according to the next address phase.
REQ-015 SHALL generate a tick every cycle while EN=1 (prescaled per REQ-020 when enabled).
REQ-016 SHALL behave as follows on a tick:
- if COUNT==COMPARE: set MATCH, and COUNT <= 0 if AUTO_RELOAD else COUNT+1;
- otherwise COUNT <= COUNT+1, wrapping 32'hFFFF_FFFF -> 0 with no flag.
REQ-017 SHALL give an AHB write to COUNT priority over a tick in the same cycle: the written value is loaded, with no increment and no match evaluation that cycle.
REQ-018 SHALL let a MATCH set from a tick win over a simultaneous W1C clear of MATCH.
REQ-019 SHALL not reset or stop COUNT when EN is cleared; COUNT holds its value.

Configuration
REQ-020 SHALL depend on the macro AHB_TIMER_PRESCALE_EN:
- defined: adds 16-bit PRESCALE (RW, reset 0) and an internal prescale counter; one tick every PRESCALE+1 enabled cycles; the prescale counter clears when EN=0 or on a PRESCALE write.
- undefined: ticks every enabled cycle; offset 0x10 is unmapped and gives an ERROR response.

Reset
REQ-021 SHALL on nrst=0 asynchronously set:
- CTRL=0, COUNT=0, COMPARE=COMPARE_RST, MATCH=0, PRESCALE=0;
- FSM=IDLE;
- hreadyout=1, hresp=0, hrdata=0, irq=0.
REQ-022 SHALL abandon any in-flight transfer on reset mid-transfer, with no register write.

Structure
REQ-023 SHALL place register offsets, CTRL bit indices and the FSM state enum in common_types_pkg; htrans_t and word_t are taken from that package.
REQ-024 SHALL keep the bus decode in the multiplexor, with the timer at 0x0003_0000-0x0003_0013; no sub-module.

Verification
REQ-025 SHALL cover these directed scenarios:
- write COMPARE=5, CTRL=0x1 -> MATCH=1 on the 6th tick, COUNT continues to 6; irq stays 0.
- CTRL=0x7, COMPARE=3 -> COUNT sequence 0,1,2,3,0,1; irq=1 after the first match; W1C to STATUS drops irq the next cycle.
- COUNT write 32'hFFFF_FFFE with EN=1 and COMPARE=0 -> counts FFFF_FFFF, 0, then MATCH sets.
- byte write (hsize=0) to 0x4 -> hreadyout 0 then 1 with hresp=1 both cycles; COUNT unchanged.
- back-to-back NONSEQ write COMPARE then read COMPARE -> read returns the written value; zero wait states.
- with AHB_TIMER_PRESCALE_EN, PRESCALE=2 -> COUNT increments every 3 cycles; without the macro, access to 0x10 -> ERROR.
